tt_um_serial_addsub: RTL and testbench

TT_UM_SERIAL_ADDSUB -- requirements
Module: tt_um_serial_addsub

---
 rtl/serial_addsub_pkg.sv | 28 ++
 rtl/full_adder_bit.sv | 20 ++
 rtl/tt_um_serial_addsub.sv | 148 ++++++++++++++
 tb/tb_tt_um_serial_addsub.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// serial_addsub_pkg : shared state encoding and uio bit positions
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int UIO_LOAD_A = 0;
  localparam int UIO_LOAD_B = 1;
  localparam int UIO_START  = 2;
  localparam int UIO_SUB    = 3;
  localparam int UIO_OVF    = 4;
  localparam int UIO_COUT   = 5;
  localparam int UIO_DONE   = 6;
  localparam int UIO_BUSY   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

`default_nettype wire

// File: rtl/full_adder_bit.sv
// ============================================================================
// full_adder_bit : single-bit full adder, reused every cycle by the serial core
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/tt_um_serial_addsub.sv
// ============================================================================
// tt_um_serial_addsub : bit-serial add/subtract unit, LSB first, one bit/cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module tt_um_serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("tt_um_serial_addsub: WIDTH must be within 2..8");
  end

  localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d, sum_q, sum_d;
  logic               cout_q, cout_d, ovf_q, ovf_d;
  logic               sub_q, sub_d, carry_q, carry_d;
  logic [2:0]         cnt_q, cnt_d;

  logic load_a, load_b, start, sub;
  logic fa_s, fa_co;
  logic unused_inputs;

  assign load_a        = uio_in[UIO_LOAD_A];
  assign load_b        = uio_in[UIO_LOAD_B];
  assign start         = uio_in[UIO_START];
  assign sub           = uio_in[UIO_SUB];
  assign unused_inputs = &{1'b0, ui_in, uio_in[7:4]};

  // Subtraction is A + ~B + 1: invert B per bit and seed the carry with sub.
  full_adder_bit u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0] ^ sub_q),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    if (ena) begin
      case (state_q)
        ST_RUN: begin
          sh_a_d  = sh_a_q >> 1;
          sh_b_d  = sh_b_q >> 1;
          sum_d   = {fa_s, sum_q[WIDTH-1:1]};
          carry_d = fa_co;
          cnt_d   = cnt_q + 3'd1;
          // Result and flags are published only here, so RUN never shows partial sums.
          if (cnt_q == LAST_BIT) begin
            state_d  = ST_DONE;
            result_d = {fa_s, sum_q[WIDTH-1:1]};
            cout_d   = fa_co;
            ovf_d    = carry_q ^ fa_co;
          end
        end
        default: begin
          if (load_a && load_b) begin
            a_d = result_q;
          end else if (load_a) begin
            a_d = ui_in[WIDTH-1:0];
          end else if (load_b) begin
            b_d = ui_in[WIDTH-1:0];
          end
          if (start) begin
            state_d = ST_RUN;
            sh_a_d  = a_d;
            sh_b_d  = b_d;
            carry_d = sub;
            sub_d   = sub;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    uo_out              = '0;
    uo_out[WIDTH-1:0]   = result_q;
    uio_out             = '0;
    uio_out[UIO_OVF]    = ovf_q;
    uio_out[UIO_COUT]   = cout_q;
    uio_out[UIO_DONE]   = (state_q == ST_DONE);
    uio_out[UIO_BUSY]   = (state_q == ST_RUN);
    uio_oe              = UIO_OE_MASK;
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_um_serial_addsub.sv
// ============================================================================
// tb_tt_um_serial_addsub : checks 8-bit and 4-bit instances against an
// arithmetic reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tt_um_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo8, uio8, oe8, uo4, uio4, oe4;

  int nvec = 0;
  int nerr = 0;

  int         W[2] = '{8, 4};
  logic [7:0] m_a[2], m_b[2], m_r[2];
  bit         m_c[2], m_v[2], m_done[2];
  bit         m_sub;

  tt_um_serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo8), .uio_out(uio8), .uio_oe(oe8)
  );

  tt_um_serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo4), .uio_out(uio4), .uio_oe(oe4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] get_uo(int k);
    return (k == 0) ? uo8 : uo4;
  endfunction

  function automatic logic [7:0] get_uio(int k);
    return (k == 0) ? uio8 : uio4;
  endfunction

  function automatic logic [7:0] get_oe(int k);
    return (k == 0) ? oe8 : oe4;
  endfunction

  function automatic logic [7:0] mask(int k);
    return 8'((1 << W[k]) - 1);
  endfunction

  // Reference: plain integer arithmetic, returns {ovf, cout, result[7:0]}.
  function automatic logic [9:0] ref_op(int w, int a, int b, bit sub);
    int m, r, sa, sb, s;
    bit c, v;
    m  = 1 << w;
    r  = sub ? (a - b + m) : (a + b);
    c  = sub ? (a >= b) : (r >= m);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    s  = sub ? sa - sb : sa + sb;
    v  = (s >= m / 2) || (s < -(m / 2));
    return {v, c, 8'(r % m)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_load(input logic [7:0] v, input logic [1:0] which);
    for (int k = 0; k < 2; k++) begin
      if (which == 2'b11)      m_a[k] = m_r[k];
      else if (which == 2'b01) m_a[k] = v & mask(k);
      else if (which == 2'b10) m_b[k] = v & mask(k);
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic [1:0] which);
    ui_in  = v;
    uio_in = {6'b0, which};
    step();
    uio_in = 8'h00;
    model_load(v, which);
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (get_uio(k) !== {1'b0, m_done[k], m_c[k], m_v[k], 4'b0} || get_uo(k) !== m_r[k]) begin
        nerr++;
        $display("FAIL load_hold[w%0d]: uio=%h uo=%h, required uio=%h uo=%h", W[k],
                 get_uio(k), get_uo(k), {1'b0, m_done[k], m_c[k], m_v[k], 4'b0}, m_r[k]);
      end
    end
  endtask

  task automatic do_start(input bit sub, input logic [1:0] which, input logic [7:0] v);
    ui_in  = v;
    uio_in = {4'b0, sub, 1'b1, which};
    step();
    uio_in = 8'h00;
    model_load(v, which);
    m_sub = sub;
  endtask

  // Follows one operation to completion; gap_at>0 freezes ena for 3 cycles
  // after that many enabled edges, disturb injects start+load_a mid-run.
  task automatic wait_op(input int gap_at, input bit disturb);
    logic [9:0] t;
    logic [7:0] er[2];
    bit ec[2], ev[2], d;
    int e, guard, gap_left;
    bit gapped, disturbed;
    logic [7:0] exp_uio, exp_uo;
    for (int k = 0; k < 2; k++) begin
      t = ref_op(W[k], int'(m_a[k]), int'(m_b[k]), m_sub);
      er[k] = t[7:0]; ec[k] = t[8]; ev[k] = t[9];
    end
    e = 0; guard = 0; gap_left = 0; gapped = 0; disturbed = 0;
    while (e < 8 && guard < 40) begin
      for (int k = 0; k < 2; k++) begin
        d = (e >= W[k]);
        exp_uio = {!d, d, d ? ec[k] : m_c[k], d ? ev[k] : m_v[k], 4'b0};
        exp_uo  = d ? er[k] : m_r[k];
        nvec++;
        if (get_uio(k) !== exp_uio || get_uo(k) !== exp_uo) begin
          nerr++;
          $display("FAIL run_step[w%0d e=%0d]: uio=%h uo=%h, required uio=%h uo=%h", W[k], e,
                   get_uio(k), get_uo(k), exp_uio, exp_uo);
        end
      end
      guard++;
      if (gap_at > 0 && e == gap_at && !gapped) begin
        gapped = 1; gap_left = 3;
      end
      ena = (gap_left == 0);
      if (ena && disturb && e == 2 && !disturbed) begin
        disturbed = 1;
        ui_in  = 8'hAA;
        uio_in = 8'h05;
      end
      step();
      uio_in = 8'h00;
      if (gap_left > 0) gap_left--;
      else e++;
    end
    ena = 1'b1;
    nvec++;
    if (e < 8) begin
      nerr++;
      $display("FAIL op_timeout: enabled edges=%0d, required 8", e);
    end
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (get_uio(k) !== {2'b01, ec[k], ev[k], 4'b0} || get_uo(k) !== er[k]) begin
        nerr++;
        $display("FAIL op_result[w%0d]: uio=%h uo=%h, required uio=%h uo=%h", W[k],
                 get_uio(k), get_uo(k), {2'b01, ec[k], ev[k], 4'b0}, er[k]);
      end
      m_r[k] = er[k]; m_c[k] = ec[k]; m_v[k] = ev[k]; m_done[k] = 1;
    end
  endtask

  // mode 0: separate loads; 1: load_a with start; 2: accumulate with start; 3: load_b with start
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit sub,
                       input int mode, input int gap_at, input bit disturb);
    case (mode)
      0: begin do_load(a, 2'b01); do_load(b, 2'b10); do_start(sub, 2'b00, 8'h00); end
      1: begin do_load(b, 2'b10); do_start(sub, 2'b01, a); end
      2: do_start(sub, 2'b11, 8'h00);
      default: do_start(sub, 2'b10, b);
    endcase
    wait_op(gap_at, disturb);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_a[k] = 0; m_b[k] = 0; m_r[k] = 0; m_c[k] = 0; m_v[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    step(); step();
    rst_n = 1'b1;
    model_reset();
    step();
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (get_uo(k) !== 8'h00 || get_uio(k) !== 8'h00 || get_oe(k) !== 8'hF0) begin
        nerr++;
        $display("FAIL reset[w%0d]: uo=%h uio=%h oe=%h, required 00 00 f0", W[k],
                 get_uo(k), get_uio(k), get_oe(k));
      end
    end
  endtask

  task automatic test_directed();
    do_op(8'h5A, 8'h33, 1'b0, 0, 0, 1'b0);
    nvec++;
    if (uo8 !== 8'h8D || uio8[6:4] !== 3'b101) begin
      nerr++; $display("FAIL add_5a_33: uo=%h flags=%b, required 8d 101", uo8, uio8[6:4]);
    end
    do_op(8'h10, 8'h20, 1'b1, 0, 0, 1'b0);
    nvec++;
    if (uo8 !== 8'hF0 || uio8[5:4] !== 2'b00) begin
      nerr++; $display("FAIL sub_10_20: uo=%h c/v=%b, required f0 00", uo8, uio8[5:4]);
    end
    do_op(8'h20, 8'h10, 1'b1, 1, 0, 1'b0);
    nvec++;
    if (uo8 !== 8'h10 || uio8[5] !== 1'b1) begin
      nerr++; $display("FAIL sub_20_10: uo=%h c=%b, required 10 1", uo8, uio8[5]);
    end
    do_op(8'hFF, 8'h01, 1'b0, 0, 0, 1'b0);
    nvec++;
    if (uo8 !== 8'h00 || uio8[5:4] !== 2'b10) begin
      nerr++; $display("FAIL add_ff_01: uo=%h c/v=%b, required 00 10", uo8, uio8[5:4]);
    end
    do_op(8'h00, 8'h00, 1'b0, 2, 0, 1'b0);
    nvec++;
    if (uo8 !== 8'h01) begin
      nerr++; $display("FAIL accumulate: uo=%h, required 01", uo8);
    end
  endtask

  task automatic test_width4();
    do_op(8'h07, 8'h01, 1'b0, 0, 0, 1'b0);
    nvec++;
    if (uo4 !== 8'h08 || uio4[4] !== 1'b1) begin
      nerr++; $display("FAIL w4_add_7_1: uo=%h ovf=%b, required 08 1", uo4, uio4[4]);
    end
  endtask

  task automatic test_run_ignore();
    do_op(8'h3C, 8'h0F, 1'b0, 0, 3, 1'b1);
    do_op(8'h00, 8'h05, 1'b1, 3, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    do_load(8'h9C, 2'b01);
    do_load(8'h41, 2'b10);
    do_start(1'b0, 2'b00, 8'h00);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (get_uo(k) !== 8'h00 || get_uio(k) !== 8'h00) begin
        nerr++;
        $display("FAIL reset_mid_run[w%0d]: uo=%h uio=%h, required 00 00", W[k], get_uo(k), get_uio(k));
      end
    end
    do_op(8'h21, 8'h12, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
            1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_width4();
    test_run_ignore();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
